// File: rtl/seq_alu.sv
// Multi-cycle ALU with a persistent ZCFNL flag register, bit-serial shifts and
// a shift-add multiplier, driven through a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int SHIFT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHIFT_W + 1;
    localparam int MSB     = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_ADDU = 4'd5;
    localparam logic [3:0] OP_ADDC = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_CMPU = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;
    localparam logic [3:0] OP_LSH  = 4'd11;
    localparam logic [3:0] OP_RSH  = 4'd12;
    localparam logic [3:0] OP_ARSH = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;

    // Flag bit positions within {Z,C,F,N,L}.
    localparam int FZ = 4;
    localparam int FC = 3;
    localparam int FF = 2;
    localparam int FN = 1;
    localparam int FL = 0;

    logic [1:0]         state;
    logic [3:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic               accept;
    logic               is_shift;
    logic [SHIFT_W-1:0] n;

    assign accept   = (state == S_IDLE) && start;
    assign is_shift = (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
    assign n        = b[SHIFT_W-1:0];

    // Single-cycle results; shifts by zero also finish here and pass a through.
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_addc;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] c_res;
    logic [4:0]       c_flags;

    always_comb begin
        sum_add  = {1'b0, a} + {1'b0, b};
        sum_addc = sum_add + {{WIDTH{1'b0}}, flags[FC]};
        diff     = {1'b0, a} - {1'b0, b};
        c_res    = '0;
        c_flags  = '0;
        case (op)
            OP_AND:  c_res = a & b;
            OP_OR:   c_res = a | b;
            OP_XOR:  c_res = a ^ b;
            OP_NOT:  c_res = ~a;
            OP_MOV:  c_res = b;
            OP_ADD: begin
                c_res       = sum_add[MSB:0];
                c_flags[FC] = sum_add[WIDTH];
                c_flags[FF] = (a[MSB] == b[MSB]) && (c_res[MSB] != a[MSB]);
            end
            OP_ADDU: begin
                c_res       = sum_add[MSB:0];
                c_flags[FC] = sum_add[WIDTH];
                c_flags[FF] = sum_add[WIDTH];
            end
            OP_ADDC: begin
                c_res       = sum_addc[MSB:0];
                c_flags[FC] = sum_addc[WIDTH];
                c_flags[FF] = (a[MSB] == b[MSB]) && (c_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                c_res       = diff[MSB:0];
                c_flags[FC] = diff[WIDTH];
                c_flags[FF] = (a[MSB] != b[MSB]) && (c_res[MSB] != a[MSB]);
            end
            OP_CMP: begin
                c_flags[FZ] = (a == b);
                c_flags[FN] = ($signed(a) < $signed(b));
                c_flags[FL] = (a < b);
            end
            OP_CMPU: begin
                c_flags[FZ] = (a == b);
                c_flags[FL] = (a < b);
            end
            OP_LSH, OP_RSH, OP_ARSH: c_res = a;
            OP_MUL:  c_res = '0;
            default: c_flags = flags;  // reserved op leaves every flag untouched
        endcase
        if (op != OP_CMP && op != OP_CMPU && op != 4'd15)
            c_flags[FZ] = (c_res == '0);
    end

    // One shift step of the working register.
    logic [WIDTH-1:0] shift_next;
    logic             shift_out;

    always_comb begin
        case (op_q)
            OP_LSH: begin
                shift_next = {acc[MSB-1:0], 1'b0};
                shift_out  = acc[MSB];
            end
            OP_RSH: begin
                shift_next = {1'b0, acc[MSB:1]};
                shift_out  = acc[0];
            end
            default: begin
                shift_next = {acc[MSB], acc[MSB:1]};
                shift_out  = acc[0];
            end
        endcase
    end

    // Shift-add step: prod holds {partial sum, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift && n != '0) begin
                            state <= S_SHIFT;
                            busy  <= 1'b1;
                            cnt   <= {1'b0, n};
                        end else if (op == OP_MUL) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(WIDTH);
                        end else begin
                            result <= c_res;
                            flags  <= c_flags;
                            done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= shift_next;
                        flags  <= {shift_next == '0, shift_out, 3'b000};
                    end
                end
                S_MUL: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= mul_next[MSB:0];
                        flags  <= {mul_next[MSB:0] == '0, |mul_next[2*WIDTH-1:WIDTH], 3'b000};
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: working registers carry no reset; every op loads them on accept
    // before they are read, so a reset here would only cost routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op;
            acc   <= a;
            mcand <= a;
            prod  <= {{WIDTH{1'b0}}, b};
        end else if (state == S_SHIFT) begin
            acc <= shift_next;
        end else if (state == S_MUL) begin
            prod <= mul_next;
        end
    end

endmodule
